mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Arbitrates the single-port unified instruction/data memory between two requesters: the instruction-fetch port (PC side) and the load/store data port (decoder/ALU side).
- Allows one outstanding transaction at a time.
- Sits between the CPU datapath and the unified memory array, sequencing read latency and returning read data.
- Data port has priority; a starvation counter guarantees forward progress for fetch.

Parameters:
INSTRUCTION_WIDTH, 18, instruction word width returned on fetch port
DATA_WIDTH, 36, memory word and data-port width
ADDR_WIDTH, 14, word address width shared by both ports
MEM_LATENCY, 1, cycles from command edge to valid i_mem_rdata (legal 1..4)
STARVE_LIMIT, 3, consecutive denied-fetch IDLE cycles before fetch is forced to win (0 = strict data priority)

Ports:
i_clk  input  1  clock
i_rst  input  1  asynchronous active-high reset
i_if_req  input  1  fetch request, held until o_if_gnt
i_if_addr  input  ADDR_WIDTH  fetch word address
o_if_gnt  output  1  fetch accepted this cycle
o_if_rvalid  output  1  one-cycle pulse, o_if_rdata valid
o_if_rdata  output  INSTRUCTION_WIDTH  fetched instruction = captured word[INSTRUCTION_WIDTH-1:0]
i_dm_req  input  1  data request, held until o_dm_gnt
i_dm_we  input  1  1 = store, 0 = load
i_dm_addr  input  ADDR_WIDTH  data word address
i_dm_wdata  input  DATA_WIDTH  store data
o_dm_gnt  output  1  data request accepted this cycle
o_dm_rvalid  output  1  one-cycle pulse, o_dm_rdata valid (loads only)
o_dm_rdata  output  DATA_WIDTH  load data
o_mem_en  output  1  memory command strobe
o_mem_we  output  1  memory write enable
o_mem_addr  output  ADDR_WIDTH  memory address
o_mem_wdata  output  DATA_WIDTH  memory write data
i_mem_rdata  input  DATA_WIDTH  memory read data, valid MEM_LATENCY cycles after command

Behaviour:
- Reset (async, i_rst=1): FSM=IDLE, latency counter=0, starve counter=0, owner=none. All outputs 0, including rdata registers. An in-flight read is dropped; no rvalid is issued after reset releases.
- States are IDLE and WAIT.
- IDLE, grant decision is combinational from requests:
  - dm_req && !(if_req && starve==STARVE_LIMIT && STARVE_LIMIT!=0) -> grant data.
  - Else if_req -> grant fetch.
  - Only one gnt is high per cycle.
- Grant cycle T: gnt=1; o_mem_en=1, and o_mem_addr, o_mem_we and o_mem_wdata are driven combinationally from the winner (o_mem_we=0 for fetch; o_mem_wdata=0 when not a store). Memory samples at the end of T.
- Store grant: stays in IDLE; a new grant is possible in T+1. No rvalid.
- Read grant (fetch or load): go to WAIT, counter=1, owner recorded.
- WAIT:
  - All gnt=0, o_mem_en=0.
  - Counter increments each cycle.
  - In the cycle where counter==MEM_LATENCY (cycle T+MEM_LATENCY), i_mem_rdata is captured at the end of the cycle into the owner's rdata register. FSM returns to IDLE.
- Response: owner's rvalid=1 during cycle T+MEM_LATENCY+1 for exactly one cycle. The rdata register holds its value until the next capture for that port.
- Back-to-back: a new grant may occur in the same cycle as rvalid (T+MEM_LATENCY+1). Read-to-read throughput is one per MEM_LATENCY+1 cycles.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) in each IDLE cycle where i_if_req=1 and o_if_gnt=0.
  - Clears on o_if_gnt.
  - Holds in WAIT.
- Requests arriving during WAIT are ignored (no gnt). Requesters must hold req/addr/we/wdata stable until gnt; deasserting before gnt is legal and cancels the request.
- Width rules:
  - o_if_rdata truncates the upper DATA_WIDTH-INSTRUCTION_WIDTH bits.
  - No address translation; both ports share one ADDR_WIDTH word address space.
- The counter is wide enough for MEM_LATENCY=4 (3 bits).

Test Plan:
- Reset then fetch only: if_req=1, addr=0x005; memory returns 0x0_0002_A5A5 -> o_if_gnt at T, o_if_rvalid at T+2 with o_if_rdata=0x2A5A5 (MEM_LATENCY=1); next gnt at T+2.
- Simultaneous requests: if_req and dm_req (load, addr=0x100, mem data 0x123456789) in the same cycle -> data granted first, o_dm_rdata=0x123456789 at T+2, fetch granted at T+2.
- Store then fetch: dm_req, we=1, addr=0x010, wdata=0xFFFFFFFFF -> o_mem_we=1 at T, no o_dm_rvalid, fetch gnt at T+1.
- Starvation: dm_req held high with continuous stores, if_req high -> fetch denied 3 IDLE cycles, granted on the 4th despite dm_req; counter clears.
- Latency: MEM_LATENCY=3 load -> rvalid exactly at T+4, no gnt at T+1..T+3 even with requests pending.
- Reset mid-read: assert i_rst at T+1 of a load -> all outputs 0 immediately; after release, no o_dm_rvalid pulse; a fresh request is granted normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: data port has priority, fetch is forced through
// after STARVE_LIMIT consecutive denied IDLE cycles. One read outstanding.
module mem_arbiter #(
  parameter int unsigned INSTRUCTION_WIDTH = 18,
  parameter int unsigned DATA_WIDTH        = 36,
  parameter int unsigned ADDR_WIDTH        = 14,
  parameter int unsigned MEM_LATENCY       = 1,
  parameter int unsigned STARVE_LIMIT      = 3
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_if_req,
  input  logic [ADDR_WIDTH-1:0]        i_if_addr,
  output logic                         o_if_gnt,
  output logic                         o_if_rvalid,
  output logic [INSTRUCTION_WIDTH-1:0] o_if_rdata,
  input  logic                         i_dm_req,
  input  logic                         i_dm_we,
  input  logic [ADDR_WIDTH-1:0]        i_dm_addr,
  input  logic [DATA_WIDTH-1:0]        i_dm_wdata,
  output logic                         o_dm_gnt,
  output logic                         o_dm_rvalid,
  output logic [DATA_WIDTH-1:0]        o_dm_rdata,
  output logic                         o_mem_en,
  output logic                         o_mem_we,
  output logic [ADDR_WIDTH-1:0]        o_mem_addr,
  output logic [DATA_WIDTH-1:0]        o_mem_wdata,
  input  logic [DATA_WIDTH-1:0]        i_mem_rdata
);

  localparam int unsigned  SW         = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [2:0]    LAT        = 3'(MEM_LATENCY);

  typedef enum logic {S_IDLE, S_WAIT} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} owner_t;

  state_t                       state;
  state_t                       state_nxt;
  owner_t                       owner;
  logic [2:0]                   lat_cnt;
  logic [SW-1:0]                starve;
  logic                         starve_force;
  logic                         grant_if;
  logic                         grant_dm;
  logic                         read_grant;
  logic                         resp_done;
  logic                         mem_en;
  logic                         mem_we;
  logic [ADDR_WIDTH-1:0]        mem_addr;
  logic [DATA_WIDTH-1:0]        mem_wdata;
  logic                         if_rvalid;
  logic                         dm_rvalid;
  logic [INSTRUCTION_WIDTH-1:0] if_rdata;
  logic [DATA_WIDTH-1:0]        dm_rdata;

  assign starve_force = (STARVE_LIMIT != 0) && (starve == STARVE_MAX);
  assign read_grant   = grant_if | (grant_dm & ~i_dm_we);
  assign resp_done    = (state == S_WAIT) && (lat_cnt == LAT);

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (read_grant) state_nxt = S_WAIT;
      S_WAIT:  if (lat_cnt == LAT) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic: grants are gated by reset so every output is 0 while it is held
  always_comb begin
    grant_if  = 1'b0;
    grant_dm  = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state == S_IDLE && !i_rst) begin
      if (i_dm_req && !(i_if_req && starve_force)) begin
        grant_dm = 1'b1;
      end else if (i_if_req) begin
        grant_if = 1'b1;
      end
    end
    if (grant_dm) begin
      mem_en   = 1'b1;
      mem_we   = i_dm_we;
      mem_addr = i_dm_addr;
      if (i_dm_we) begin
        mem_wdata = i_dm_wdata;
      end
    end else if (grant_if) begin
      mem_en   = 1'b1;
      mem_addr = i_if_addr;
    end
  end

  // Latency counter, owner tracking and response capture
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      lat_cnt   <= '0;
      owner     <= OWN_NONE;
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      if (read_grant) begin
        lat_cnt <= 3'd1;
        owner   <= grant_if ? OWN_IF : OWN_DM;
      end else if (resp_done) begin
        lat_cnt <= '0;
        owner   <= OWN_NONE;
        if (owner == OWN_IF) begin
          if_rdata  <= i_mem_rdata[INSTRUCTION_WIDTH-1:0];
          if_rvalid <= 1'b1;
        end else if (owner == OWN_DM) begin
          dm_rdata  <= i_mem_rdata;
          dm_rvalid <= 1'b1;
        end
      end else if (state == S_WAIT) begin
        lat_cnt <= lat_cnt + 3'd1;
      end
    end
  end

  // Starvation counter: counts denied fetch cycles in IDLE, holds in WAIT
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      starve <= '0;
    end else if (grant_if) begin
      starve <= '0;
    end else if (state == S_IDLE && i_if_req && starve != STARVE_MAX) begin
      starve <= starve + SW'(1);
    end
  end

  assign o_if_gnt    = grant_if;
  assign o_dm_gnt    = grant_dm;
  assign o_mem_en    = mem_en;
  assign o_mem_we    = mem_we;
  assign o_mem_addr  = mem_addr;
  assign o_mem_wdata = mem_wdata;
  assign o_if_rvalid = if_rvalid;
  assign o_if_rdata  = if_rdata;
  assign o_dm_rvalid = dm_rvalid;
  assign o_dm_rdata  = dm_rdata;

endmodule
